ifetch_unit: RTL and testbench

//  Owns the fetch PC and drives the instruction bus, one request in flight at a time.

---
 rtl/ifetch_unit_pkg.sv | 29 ++
 rtl/ifetch_unit_if.sv | 24 ++
 rtl/ifetch_unit.sv | 152 +++++++++++++++
 tb/tb_ifetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM state, reset PC and bus records.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // A PC may go on the bus only when it is word aligned.
    function automatic logic word_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the memory side (slave).
interface ifetch_unit_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch PC owner: one instruction bus transaction in flight, redirects kill stale data,
// fetched word is held until the fetch stage accepts it.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    ifetch_unit_if.master       ibus,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    output logic                out_valid,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_instr,
    output logic                out_adel
);

    ifetch_state_t state_q, state_s;
    logic [31:0]   pc_q, pc_s;
    logic [31:0]   redir_q, redir_s;
    logic          kill_q, kill_s;
    logic [31:0]   instr_q, instr_s;
    logic          adel_q, adel_s;
    logic          out_valid_q;
    logic          arrive_s;
    ibus_resp_t    resp_s;
    ibus_req_t     req_s;

    assign resp_s = '{addr_ok: ibus.iresp_addr_ok,
                      data_ok: ibus.iresp_data_ok,
                      data:    ibus.iresp_data};

    // The request is gated by resetn so nothing reaches the bus while the block is in reset.
    assign req_s = '{valid: resetn && (state_q == S_REQ) && word_aligned(pc_q[1:0]),
                     addr:  pc_q};

    assign ibus.ireq_valid = req_s.valid;
    assign ibus.ireq_addr  = req_s.addr;
    assign out_valid       = out_valid_q;
    assign out_pc          = pc_q;
    assign out_instr       = instr_q;
    assign out_adel        = adel_q;

    // Next-state logic: request, wait for data, hold for the fetch stage.
    always_comb begin
        state_s  = state_q;
        pc_s     = pc_q;
        redir_s  = redir_q;
        kill_s   = kill_q;
        instr_s  = instr_q;
        adel_s   = adel_q;
        arrive_s = 1'b0;

        case (state_q)
            S_REQ: begin
                if (!word_aligned(pc_q[1:0])) begin
                    // No bus access was made, so a redirect can simply replace the PC.
                    if (redirect_valid) begin
                        pc_s = redirect_pc;
                    end else begin
                        state_s = S_HOLD;
                        adel_s  = 1'b1;
                        instr_s = 32'h0000_0000;
                    end
                end else if (resp_s.addr_ok && resp_s.data_ok) begin
                    arrive_s = 1'b1;
                end else if (resp_s.addr_ok) begin
                    state_s = S_WAIT;
                    if (redirect_valid) begin
                        redir_s = redirect_pc;
                        kill_s  = 1'b1;
                    end else begin
                        kill_s = kill_q;
                    end
                end else if (redirect_valid) begin
                    // Address must stay stable until accepted; remember the target instead.
                    redir_s = redirect_pc;
                    kill_s  = 1'b1;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (resp_s.data_ok) begin
                    arrive_s = 1'b1;
                end else if (redirect_valid) begin
                    redir_s = redirect_pc;
                    kill_s  = 1'b1;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    state_s = S_REQ;
                end else if (!stall) begin
                    pc_s    = pc_q + PC_STEP;
                    state_s = S_REQ;
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: begin
                state_s = S_REQ;
            end
        endcase

        // Data arrival: a redirect this cycle or an earlier kill both drop the word.
        if (arrive_s) begin
            if (redirect_valid) begin
                pc_s    = redirect_pc;
                kill_s  = 1'b0;
                state_s = S_REQ;
            end else if (kill_q) begin
                pc_s    = redir_q;
                kill_s  = 1'b0;
                state_s = S_REQ;
            end else begin
                instr_s = resp_s.data;
                adel_s  = 1'b0;
                state_s = S_HOLD;
            end
        end else begin
            arrive_s = 1'b0;
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            redir_q     <= RESET_PC;
            kill_q      <= 1'b0;
            instr_q     <= 32'h0000_0000;
            adel_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_s;
            pc_q        <= pc_s;
            redir_q     <= redir_s;
            kill_q      <= kill_s;
            instr_q     <= instr_s;
            adel_q      <= adel_s;
            out_valid_q <= (state_s == S_HOLD);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed per-cycle vector table plus randomized bus/redirect traffic
// checked against a transaction-level PC/instruction model.
module tb_ifetch_unit;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    int total = 0;
    int bad   = 0;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(32'hbfc0_0000)) u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .ibus           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_adel       (out_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        a;
        logic        d;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic        iv;
        logic [31:0] ia;
        logic        ov;
        logic [31:0] opc;
        logic [31:0] oin;
        logic        oad;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic row(input logic rn, input logic a, input logic d, input logic [31:0] data,
                       input logic rv, input logic [31:0] rpc, input logic st,
                       input logic iv, input logic [31:0] ia,
                       input logic ov, input logic [31:0] opc, input logic [31:0] oin,
                       input logic oad);
        vec_t v;
        v.rn = rn; v.a = a; v.d = d; v.data = data; v.rv = rv; v.rpc = rpc; v.st = st;
        v.iv = iv; v.ia = ia; v.ov = ov; v.opc = opc; v.oin = oin; v.oad = oad;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
    endfunction

    task automatic drive(input logic rn, input logic a, input logic d, input logic [31:0] data,
                         input logic rv, input logic [31:0] rpc, input logic st);
        resetn             = rn;
        bus.iresp_addr_ok  = a;
        bus.iresp_data_ok  = d;
        bus.iresp_data     = data;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        stall              = st;
    endtask

    // Random-phase state: model PC and a simple bus slave.
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_addr;
    logic [31:0] rpc_r;
    bit          pending;
    bit          prev_stuck;
    bit          st_r;
    bit          rv_r;
    int          dly;
    int          accepts;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);

        // Zero-wait fetch, then a 5-cycle stall in hold.
        row(0,0,0,32'h0,         0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'hbfc00000, 0,32'h0,32'h0,0);
        row(1,0,1,32'h11111111,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 0,32'h0,        1,32'hbfc00000,32'h11111111,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'hbfc00004, 0,32'h0,32'h0,0);
        row(1,0,1,32'h22222222,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        for (int i = 0; i < 5; i++)
            row(1,0,0,32'h0,     0,32'h0,1, 0,32'h0,        1,32'hbfc00004,32'h22222222,0);
        row(1,0,0,32'h0,         0,32'h0,0, 0,32'h0,        1,32'hbfc00004,32'h22222222,0);
        // addr_ok held off for 4 cycles.
        for (int i = 0; i < 4; i++)
            row(1,0,0,32'h0,     0,32'h0,0, 1,32'hbfc00008, 0,32'h0,32'h0,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'hbfc00008, 0,32'h0,32'h0,0);
        row(1,0,1,32'h33333333,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        // Redirect with !stall in hold drops the held word.
        row(1,0,0,32'h0,         1,32'h80002000,0, 0,32'h0, 1,32'hbfc00008,32'h33333333,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'h80002000, 0,32'h0,32'h0,0);
        // Redirect during wait: deadbeef must never show.
        row(1,0,0,32'h0,         1,32'h80001000,0, 0,32'h0, 0,32'h0,32'h0,0);
        row(1,0,1,32'hdeadbeef,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'h80001000, 0,32'h0,32'h0,0);
        row(1,0,1,32'h44444444,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 0,32'h0,        1,32'h80001000,32'h44444444,0);
        // Redirect to a misaligned PC before addr_ok; then same-cycle addr/data is killed.
        row(1,0,0,32'h0,         1,32'h80000002,0, 1,32'h80001004, 0,32'h0,32'h0,0);
        row(1,1,1,32'h55555555,  0,32'h0,0, 1,32'h80001004, 0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,1, 0,32'h0,        1,32'h80000002,32'h0,1);
        row(1,0,0,32'h0,         1,32'h80000100,0, 0,32'h0, 1,32'h80000002,32'h0,1);
        row(1,1,1,32'h66666666,  0,32'h0,0, 1,32'h80000100, 0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 0,32'h0,        1,32'h80000100,32'h66666666,0);
        // Redirect on the exact data_ok cycle.
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'h80000104, 0,32'h0,32'h0,0);
        row(1,0,1,32'h77777777,  1,32'h80000200,0, 0,32'h0, 0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 1,32'h80000200, 0,32'h0,32'h0,0);
        // Reset with a request on the bus, then PC wrap at the top of the address space.
        row(0,0,0,32'h0,         0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 1,32'hbfc00000, 0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         1,32'hfffffffc,0, 1,32'hbfc00000, 0,32'h0,32'h0,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'hbfc00000, 0,32'h0,32'h0,0);
        row(1,0,1,32'h99999999,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,1,0,32'h0,         0,32'h0,0, 1,32'hfffffffc, 0,32'h0,32'h0,0);
        row(1,0,1,32'h88888888,  0,32'h0,0, 0,32'h0,        0,32'h0,32'h0,0);
        row(1,0,0,32'h0,         0,32'h0,0, 0,32'h0,        1,32'hfffffffc,32'h88888888,0);
        row(1,0,0,32'h0,         0,32'h0,0, 1,32'h00000000, 0,32'h0,32'h0,0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rn, vq[i].a, vq[i].d, vq[i].data, vq[i].rv, vq[i].rpc, vq[i].st);
            #1;
            chk($sformatf("row%0d.ireq_valid", i), {31'h0, bus.ireq_valid}, {31'h0, vq[i].iv});
            chk($sformatf("row%0d.out_valid", i),  {31'h0, out_valid},      {31'h0, vq[i].ov});
            if (vq[i].iv) chk($sformatf("row%0d.ireq_addr", i), bus.ireq_addr, vq[i].ia);
            if (vq[i].ov) begin
                chk($sformatf("row%0d.out_pc", i),    out_pc,    vq[i].opc);
                chk($sformatf("row%0d.out_instr", i), out_instr, vq[i].oin);
                chk($sformatf("row%0d.out_adel", i),  {31'h0, out_adel}, {31'h0, vq[i].oad});
            end
        end

        // Reset while a transaction is outstanding: nothing survives.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 chk("midrst.pre_addr", bus.ireq_addr, 32'h0000_0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'hcafef00d, 1'b0, 32'h0, 1'b0);
        #1 chk("midrst.ireq_valid_in_reset", {31'h0, bus.ireq_valid}, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("midrst.ireq_valid", {31'h0, bus.ireq_valid}, 32'h1);
        chk("midrst.ireq_addr",  bus.ireq_addr, 32'hbfc0_0000);
        chk("midrst.out_valid",  {31'h0, out_valid}, 32'h0);
        chk("midrst.out_instr",  out_instr, 32'h0);

        // Randomized traffic against the PC-stream model.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exp_pc     = 32'hbfc0_0000;
        pending    = 1'b0;
        prev_stuck = 1'b0;
        prev_addr  = 32'h0;
        dly        = 0;
        accepts    = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            st_r = ($urandom_range(0, 9) < 3);
            rv_r = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0:       rpc_r = 32'h8000_0000 | ($urandom_range(0, 255) << 2) | 32'h2;
                1:       rpc_r = ($urandom_range(0, 1) == 0) ? 32'hffff_fffc : 32'hffff_fff8;
                default: rpc_r = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            endcase
            drive(1'b1, 1'b0, 1'b0, 32'h0, rv_r, rpc_r, st_r);
            if (pending) begin
                if (dly == 0) begin
                    bus.iresp_data_ok = 1'b1;
                    bus.iresp_data    = mem_word(pend_addr);
                end
            end else if (bus.ireq_valid && ($urandom_range(0, 9) < 6)) begin
                bus.iresp_addr_ok = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    bus.iresp_data_ok = 1'b1;
                    bus.iresp_data    = mem_word(bus.ireq_addr);
                end
            end
            #1;
            if (pending) chk("rand.req_while_outstanding", {31'h0, bus.ireq_valid}, 32'h0);
            if (prev_stuck) begin
                chk("rand.req_valid_held", {31'h0, bus.ireq_valid}, 32'h1);
                chk("rand.req_addr_held",  bus.ireq_addr, prev_addr);
            end
            if (out_valid && !st_r && !rv_r) begin
                chk("rand.out_pc",   out_pc, exp_pc);
                chk("rand.out_adel", {31'h0, out_adel}, {31'h0, (exp_pc[1:0] != 2'b00)});
                chk("rand.out_instr", out_instr,
                    (exp_pc[1:0] != 2'b00) ? 32'h0 : mem_word(exp_pc));
                exp_pc  = exp_pc + 32'd4;
                accepts = accepts + 1;
            end
            if (rv_r) exp_pc = rpc_r;
            prev_stuck = bus.ireq_valid && !bus.iresp_addr_ok;
            prev_addr  = bus.ireq_addr;
            if (pending) begin
                if (dly == 0) pending = 1'b0;
                else dly = dly - 1;
            end else if (bus.iresp_addr_ok && !bus.iresp_data_ok) begin
                pending   = 1'b1;
                dly       = $urandom_range(0, 3);
                pend_addr = bus.ireq_addr;
            end
        end
        chk("rand.enough_accepts", {31'h0, (accepts >= 200)}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
